// File: rtl/hsv_wheel_pwm_pkg.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hsv_pkg : sector encoding, direction constants and sector step helper
// Revision: 1.0
// ----------------------------------------------------------------------------
package hsv_pkg;

   typedef enum logic [2:0] {
      SEC_R_Y = 3'd0,
      SEC_Y_G = 3'd1,
      SEC_G_C = 3'd2,
      SEC_C_B = 3'd3,
      SEC_B_M = 3'd4,
      SEC_M_R = 3'd5
   } sector_t;

   localparam logic DIR_FWD = 1'b0;
   localparam logic DIR_REV = 1'b1;

   // Successor (forward) or predecessor (reverse) on the six-sector ring.
   function automatic sector_t sector_step(input sector_t s, input logic d);
      sector_t r;
      if (d == DIR_FWD) r = (s == SEC_M_R) ? SEC_R_Y : sector_t'(s + 3'd1);
      else              r = (s == SEC_R_Y) ? SEC_M_R : sector_t'(s - 3'd1);
      return r;
   endfunction

endpackage
`default_nettype wire

// File: rtl/hsv_wheel_pwm_channel.sv
`default_nettype none
// ----------------------------------------------------------------------------
// pwm_channel : one PWM output with a duty latch updated only at period end
// Revision: 1.0
// ----------------------------------------------------------------------------
module pwm_channel #(
   parameter int                DUTY_W   = 11,
   parameter logic [DUTY_W-1:0] RST_DUTY = '0
) (
   input  logic              clk,
   input  logic              rst,
   input  logic [DUTY_W-1:0] pwm_cnt,
   input  logic              period_end,
   input  logic [DUTY_W-1:0] duty,
   output logic              pwm
);

   logic [DUTY_W-1:0] r_act;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_act <= RST_DUTY;
         pwm   <= 1'b0;
      end else begin
         if (period_end) r_act <= duty;
         pwm <= (pwm_cnt < r_act);
      end
   end

endmodule
`default_nettype wire

// File: rtl/hsv_wheel_pwm.sv
`default_nettype none
// ----------------------------------------------------------------------------
// hsv_wheel_pwm : HSV hue-wheel sequencer driving three PWM channels
// Revision: 1.0
// ----------------------------------------------------------------------------
module hsv_wheel_pwm
   import hsv_pkg::*;
#(
   parameter int PWM_INTERVAL     = 1200,
   parameter int STEPS_PER_SECTOR = 100,
   parameter int STEP_INTERVAL    = 20000,
   parameter int DUTY_W           = $clog2(PWM_INTERVAL + 1)
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              en,
   input  logic              dir,
   output logic [DUTY_W-1:0] duty_r,
   output logic [DUTY_W-1:0] duty_g,
   output logic [DUTY_W-1:0] duty_b,
   output logic              pwm_r,
   output logic              pwm_g,
   output logic              pwm_b,
   output logic [2:0]        sector,
   output logic              sector_wrap
);

   localparam int INC    = PWM_INTERVAL / STEPS_PER_SECTOR;
   localparam int STEP_W = (STEP_INTERVAL > 1) ? $clog2(STEP_INTERVAL) : 1;
   localparam int POS_W  = (STEPS_PER_SECTOR > 1) ? $clog2(STEPS_PER_SECTOR) : 1;

   localparam logic [DUTY_W-1:0] c_max       = DUTY_W'(PWM_INTERVAL);
   localparam logic [DUTY_W-1:0] c_inc       = DUTY_W'(INC);
   localparam logic [DUTY_W-1:0] c_pwm_last  = DUTY_W'(PWM_INTERVAL - 1);
   localparam logic [STEP_W-1:0] c_step_last = STEP_W'(STEP_INTERVAL - 1);
   localparam logic [POS_W-1:0]  c_pos_last  = POS_W'(STEPS_PER_SECTOR - 1);

   generate
      if (PWM_INTERVAL < 1 || STEPS_PER_SECTOR < 1 || STEP_INTERVAL < 1 ||
          (PWM_INTERVAL % STEPS_PER_SECTOR) != 0) begin : g_bad_params
         $error("hsv_wheel_pwm: illegal parameter set");
      end
   endgenerate

   logic [STEP_W-1:0] r_step_cnt;
   logic [POS_W-1:0]  r_pos;
   sector_t           r_sector;
   logic              r_wrap;
   logic [DUTY_W-1:0] r_pwm_cnt;

   logic              w_tick;
   logic              w_period_end;
   logic [DUTY_W-1:0] w_rise;
   logic [DUTY_W-1:0] w_fall;
   logic [DUTY_W-1:0] w_dr;
   logic [DUTY_W-1:0] w_dg;
   logic [DUTY_W-1:0] w_db;

   assign w_tick       = en && (r_step_cnt == c_step_last);
   assign w_period_end = (r_pwm_cnt == c_pwm_last);
   assign sector       = r_sector;
   assign sector_wrap  = r_wrap;

   // Hue pointer: wrap flag is registered alongside the sector it describes.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_step_cnt <= '0;
         r_pos      <= '0;
         r_sector   <= SEC_R_Y;
         r_wrap     <= 1'b0;
      end else begin
         r_wrap <= 1'b0;
         if (w_tick) begin
            r_step_cnt <= '0;
            if (dir == DIR_REV) begin
               if (r_pos == '0) begin
                  r_pos    <= c_pos_last;
                  r_sector <= sector_step(r_sector, dir);
                  r_wrap   <= (r_sector == SEC_R_Y);
               end else begin
                  r_pos <= r_pos - 1'b1;
               end
            end else begin
               if (r_pos == c_pos_last) begin
                  r_pos    <= '0;
                  r_sector <= sector_step(r_sector, dir);
                  r_wrap   <= (r_sector == SEC_M_R);
               end else begin
                  r_pos <= r_pos + 1'b1;
               end
            end
         end else if (en) begin
            r_step_cnt <= r_step_cnt + 1'b1;
         end
      end
   end

   assign w_rise = DUTY_W'(r_pos) * c_inc;
   assign w_fall = c_max - w_rise;

   always_comb begin
      w_dr = '0;
      w_dg = '0;
      w_db = '0;
      case (r_sector)
         SEC_R_Y: begin w_dr = c_max;  w_dg = w_rise; end
         SEC_Y_G: begin w_dr = w_fall; w_dg = c_max;  end
         SEC_G_C: begin w_dg = c_max;  w_db = w_rise; end
         SEC_C_B: begin w_dg = w_fall; w_db = c_max;  end
         SEC_B_M: begin w_dr = w_rise; w_db = c_max;  end
         SEC_M_R: begin w_dr = c_max;  w_db = w_fall; end
         default: ;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         duty_r    <= c_max;
         duty_g    <= '0;
         duty_b    <= '0;
         r_pwm_cnt <= '0;
      end else begin
         duty_r    <= w_dr;
         duty_g    <= w_dg;
         duty_b    <= w_db;
         r_pwm_cnt <= w_period_end ? '0 : r_pwm_cnt + 1'b1;
      end
   end

   pwm_channel #(.DUTY_W(DUTY_W), .RST_DUTY(c_max)) u_pwm_r (
      .clk(clk), .rst(rst), .pwm_cnt(r_pwm_cnt), .period_end(w_period_end),
      .duty(duty_r), .pwm(pwm_r)
   );

   pwm_channel #(.DUTY_W(DUTY_W), .RST_DUTY('0)) u_pwm_g (
      .clk(clk), .rst(rst), .pwm_cnt(r_pwm_cnt), .period_end(w_period_end),
      .duty(duty_g), .pwm(pwm_g)
   );

   pwm_channel #(.DUTY_W(DUTY_W), .RST_DUTY('0)) u_pwm_b (
      .clk(clk), .rst(rst), .pwm_cnt(r_pwm_cnt), .period_end(w_period_end),
      .duty(duty_b), .pwm(pwm_b)
   );

endmodule
`default_nettype wire

// File: tb/tb_hsv_wheel_pwm.sv
`default_nettype none
// ----------------------------------------------------------------------------
// tb_hsv_wheel_pwm : directed bench, PWM_INTERVAL=12, STEPS=4, STEP_INTERVAL=3
// Revision: 1.0
// ----------------------------------------------------------------------------
module tb_hsv_wheel_pwm;

   logic       clk = 1'b0;
   logic       rst = 1'b1;
   logic       en  = 1'b0;
   logic       dir = 1'b0;
   logic [3:0] duty_r, duty_g, duty_b;
   logic       pwm_r, pwm_g, pwm_b;
   logic [2:0] sector;
   logic       sector_wrap;

   int n_checks = 0;
   int n_fail   = 0;

   hsv_wheel_pwm #(
      .PWM_INTERVAL(12), .STEPS_PER_SECTOR(4), .STEP_INTERVAL(3)
   ) dut (
      .clk(clk), .rst(rst), .en(en), .dir(dir),
      .duty_r(duty_r), .duty_g(duty_g), .duty_b(duty_b),
      .pwm_r(pwm_r), .pwm_g(pwm_g), .pwm_b(pwm_b),
      .sector(sector), .sector_wrap(sector_wrap)
   );

   always #5 clk = ~clk;

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic do_reset();
      rst = 1'b1; en = 1'b0; dir = 1'b0;
      step();
      step();
      rst = 1'b0;
   endtask

   task automatic test_reset();
      do_reset();
      n_checks++;
      if ({duty_r, duty_g, duty_b} !== {4'd12, 4'd0, 4'd0}) begin
         n_fail++; $display("FAIL reset_duty: got %0d,%0d,%0d want 12,0,0", duty_r, duty_g, duty_b);
      end
      n_checks++;
      if ({sector, sector_wrap, pwm_r, pwm_g, pwm_b} !== 7'b000_0000) begin
         n_fail++; $display("FAIL reset_flags: sector=%0d wrap=%b pwm=%b%b%b want 0,0,000",
                            sector, sector_wrap, pwm_r, pwm_g, pwm_b);
      end
      for (int i = 1; i <= 30; i++) begin
         step();
         n_checks++;
         if ({pwm_r, pwm_g, pwm_b} !== 3'b100) begin
            n_fail++; $display("FAIL reset_pwm edge %0d: got %b%b%b want 100", i, pwm_r, pwm_g, pwm_b);
         end
      end
   endtask

   task automatic test_forward();
      int wraps = 0;
      int wrap_edge = -1;
      do_reset();
      en = 1'b1;
      for (int i = 1; i <= 73; i++) begin
         step();
         if (sector_wrap === 1'b1) begin wraps++; wrap_edge = i; end
         if (i == 4) begin
            n_checks++;
            if ({sector, duty_r, duty_g, duty_b} !== {3'd0, 4'd12, 4'd3, 4'd0}) begin
               n_fail++; $display("FAIL fwd_tick1: got s%0d %0d,%0d,%0d want s0 12,3,0", sector, duty_r, duty_g, duty_b);
            end
         end
         if (i == 13) begin
            n_checks++;
            if ({sector, duty_r, duty_g, duty_b} !== {3'd1, 4'd12, 4'd12, 4'd0}) begin
               n_fail++; $display("FAIL fwd_tick4: got s%0d %0d,%0d,%0d want s1 12,12,0", sector, duty_r, duty_g, duty_b);
            end
         end
         if (i == 37) begin
            n_checks++;
            if ({sector, duty_r, duty_g, duty_b} !== {3'd3, 4'd0, 4'd12, 4'd12}) begin
               n_fail++; $display("FAIL fwd_tick12: got s%0d %0d,%0d,%0d want s3 0,12,12", sector, duty_r, duty_g, duty_b);
            end
         end
         if (i == 53) begin
            n_checks++;
            if ({sector, duty_r, duty_g, duty_b} !== {3'd4, 4'd3, 4'd0, 4'd12}) begin
               n_fail++; $display("FAIL fwd_tick17: got s%0d %0d,%0d,%0d want s4 3,0,12", sector, duty_r, duty_g, duty_b);
            end
         end
      end
      n_checks++;
      if ({sector, duty_r, duty_g, duty_b} !== {3'd0, 4'd12, 4'd0, 4'd0}) begin
         n_fail++; $display("FAIL fwd_tick24: got s%0d %0d,%0d,%0d want s0 12,0,0", sector, duty_r, duty_g, duty_b);
      end
      n_checks++;
      if (wraps != 1 || wrap_edge != 72) begin
         n_fail++; $display("FAIL fwd_wrap: got %0d pulses last at edge %0d want 1 at edge 72", wraps, wrap_edge);
      end
   endtask

   task automatic test_reverse();
      do_reset();
      en = 1'b1; dir = 1'b1;
      step(); step(); step();
      n_checks++;
      if ({sector, sector_wrap} !== {3'd5, 1'b1}) begin
         n_fail++; $display("FAIL rev_tick1: got s%0d wrap=%b want s5 wrap=1", sector, sector_wrap);
      end
      step();
      n_checks++;
      if ({sector_wrap, duty_r, duty_g, duty_b} !== {1'b0, 4'd12, 4'd0, 4'd3}) begin
         n_fail++; $display("FAIL rev_duty: got wrap=%b %0d,%0d,%0d want wrap=0 12,0,3", sector_wrap, duty_r, duty_g, duty_b);
      end
      dir = 1'b0;
      step(); step();
      n_checks++;
      if ({sector, sector_wrap} !== {3'd0, 1'b1}) begin
         n_fail++; $display("FAIL dir_change: got s%0d wrap=%b want s0 wrap=1", sector, sector_wrap);
      end
   endtask

   task automatic test_pause();
      do_reset();
      en = 1'b1;
      step();
      en = 1'b0;
      repeat (50) step();
      n_checks++;
      if ({sector, sector_wrap, duty_r, duty_g, duty_b} !== {3'd0, 1'b0, 4'd12, 4'd0, 4'd0}) begin
         n_fail++; $display("FAIL pause_frozen: got s%0d %0d,%0d,%0d want s0 12,0,0", sector, duty_r, duty_g, duty_b);
      end
      en = 1'b1;
      step(); step();
      n_checks++;
      if (duty_g !== 4'd0) begin
         n_fail++; $display("FAIL pause_early: got duty_g=%0d want 0", duty_g);
      end
      step();
      n_checks++;
      if (duty_g !== 4'd3) begin
         n_fail++; $display("FAIL pause_resume: got duty_g=%0d want 3", duty_g);
      end
   endtask

   task automatic test_pwm_window();
      logic exp_g, exp_r;
      int highs_g = 0;
      do_reset();
      en = 1'b1;
      for (int i = 1; i <= 36; i++) begin
         step();
         exp_g = (i >= 13 && i <= 21) || (i >= 25);
         exp_r = (i <= 27);
         if (i >= 13 && i <= 24 && pwm_g === 1'b1) highs_g++;
         n_checks++;
         if ({pwm_r, pwm_g, pwm_b} !== {exp_r, exp_g, 1'b0}) begin
            n_fail++; $display("FAIL pwm_window edge %0d: got %b%b%b want %b%b0", i, pwm_r, pwm_g, pwm_b, exp_r, exp_g);
         end
      end
      n_checks++;
      if (highs_g != 9) begin
         n_fail++; $display("FAIL pwm_g_highs: got %0d want 9", highs_g);
      end
   endtask

   task automatic test_reset_mid();
      do_reset();
      en = 1'b1;
      repeat (38) step();
      n_checks++;
      if (sector !== 3'd3) begin
         n_fail++; $display("FAIL mid_precond: got s%0d want s3", sector);
      end
      rst = 1'b1; dir = 1'b1;
      step();
      n_checks++;
      if ({sector, sector_wrap, duty_r, duty_g, duty_b, pwm_r, pwm_g, pwm_b} !==
          {3'd0, 1'b0, 4'd12, 4'd0, 4'd0, 3'b000}) begin
         n_fail++; $display("FAIL mid_reset: got s%0d wrap=%b %0d,%0d,%0d pwm=%b%b%b want s0 0 12,0,0 000",
                            sector, sector_wrap, duty_r, duty_g, duty_b, pwm_r, pwm_g, pwm_b);
      end
      rst = 1'b0; en = 1'b1; dir = 1'b1;
      step(); step();
      rst = 1'b1;
      step();
      n_checks++;
      if ({sector, sector_wrap} !== {3'd0, 1'b0}) begin
         n_fail++; $display("FAIL reset_prio: got s%0d wrap=%b want s0 wrap=0", sector, sector_wrap);
      end
      rst = 1'b0;
      step();
      n_checks++;
      if (pwm_r !== 1'b1) begin
         n_fail++; $display("FAIL post_reset_pwm: got pwm_r=%b want 1", pwm_r);
      end
   endtask

   initial begin
      test_reset();
      test_forward();
      test_reverse();
      test_pause();
      test_pwm_window();
      test_reset_mid();
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
`default_nettype wire

// File: doc/hsv_wheel_pwm.md
# hsv_wheel_pwm

Parametrised HSV colour-wheel generator with integrated three-channel PWM, driving an RGB LED directly from one clock domain. A step-interval counter advances a (sector, position) hue pointer through six 60° sectors, forward or in reverse, with run/pause control. RGB duty values are derived from the pointer, and glitch-free PWM waveforms are produced from them. It sits between the board clock and the LED pins and replaces any derived-clock fade logic; all state is clocked by `clk` and advanced by enables only.

## Interface
- `PWM_INTERVAL`, 1200: PWM period in `clk` cycles; also the full-scale duty value (100 µs at 12 MHz).
- `STEPS_PER_SECTOR`, 100: hue steps per 60° sector. Must divide `PWM_INTERVAL`.
- `STEP_INTERVAL`, 20000: `clk` cycles per hue step. Full revolution is 6·100·20000 = 12,000,000 cycles, i.e. 1 s.
- `DUTY_W`, `$clog2(PWM_INTERVAL+1)`: duty width (derived; 11 by default).
- `clk`  in  1  system clock; the only clock.
- `rst`  in  1  reset; synchronous, active-high.
- `en`  in  1  1 = hue advances; 0 = hue frozen, PWM keeps running.
- `dir`  in  1  0 = forward (R→Y→G→C→B→M), 1 = reverse.
- `duty_r`, `duty_g`, `duty_b`  out  `DUTY_W`  current duty values, registered.
- `pwm_r`, `pwm_g`, `pwm_b`  out  1  PWM outputs, registered, active-high.
- `sector`  out  3  current sector, 0..5.
- `sector_wrap`  out  1  one-cycle pulse when `sector` wraps (5→0 forward, 0→5 reverse).

## Operation
- `INC = PWM_INTERVAL / STEPS_PER_SECTOR`.
- Hue pointer: `sector` 0..5 and `pos` 0..`STEPS_PER_SECTOR`-1.
- `rise = pos·INC`; `fall = PWM_INTERVAL − pos·INC`. Both fit `DUTY_W` bits without overflow.
- Duty per sector, given as (R, G, B), with MAX = `PWM_INTERVAL`:
  - 0: (MAX, rise, 0)
  - 1: (fall, MAX, 0)
  - 2: (0, MAX, rise)
  - 3: (0, fall, MAX)
  - 4: (rise, 0, MAX)
  - 5: (MAX, 0, fall)
- Step counter `step_cnt` runs 0..`STEP_INTERVAL`-1 only while `en`=1, and holds its value while `en`=0.
- The step tick occurs when `step_cnt`=`STEP_INTERVAL`-1 and `en`=1. On the tick, `step_cnt`→0 and the pointer moves:
  - Forward: `pos`+1. At the last `pos`, `pos`→0 and `sector`+1 (mod 6).
  - Reverse: `pos`−1. At `pos`=0, `pos`→`STEPS_PER_SECTOR`-1 and `sector`−1 (mod 6).
- `dir` is sampled only at the tick. A change in `dir` takes effect at the next tick, with no extra step.
- `sector_wrap` is 1 in exactly the cycle in which a wrapped `sector` value first appears. Otherwise it is 0.
- PWM counter `pwm_cnt` runs free 0..`PWM_INTERVAL`-1 and is independent of `en`.
- Each channel has an active duty `act`. `act` loads from `duty_x` only when `pwm_cnt`=`PWM_INTERVAL`-1, so a period is never cut short or stretched.
- `pwm_x` is registered as (`pwm_cnt` < `act`):
  - `act`=0 gives a constant low output.
  - `act`=MAX gives a constant high output.

## Timing
- Reset values:
  - `step_cnt`=0, `sector`=0, `pos`=0, `pwm_cnt`=0.
  - `duty_r`=MAX, `duty_g`=0, `duty_b`=0; `act` equals these duty values.
  - `pwm_r`=`pwm_g`=`pwm_b`=0, `sector_wrap`=0.
- Reset asserted mid-operation restores all reset values at the next edge, regardless of `en`/`dir`.
- `rst` has priority over every other event.
- Latency:
  - Tick edge → `pos`/`sector` update on the same edge.
  - `duty_x` updates on the following edge (1 cycle).
  - `pwm_x` reflects a new duty from the first cycle of the next PWM period.
- `pwm_x` lags the compare of `pwm_cnt`/`act` by 1 cycle. The first cycle after reset release shows `pwm_r`=1.
- A tick coinciding with a PWM period boundary latches the old duty. The new duty lands at the following boundary.
- `en` deasserting in the tick cycle suppresses that tick.

## Structure
- Shared package `hsv_pkg`:
  - `sector_t`, a 3-bit enum: `SEC_R_Y`, `SEC_Y_G`, `SEC_G_C`, `SEC_C_B`, `SEC_B_M`, `SEC_M_R`.
  - `DIR_FWD`/`DIR_REV` constants.
  - A sector-successor/predecessor function.
- Sub-module `pwm_channel`, instantiated three times:
  - Inputs: `clk`, `rst`, shared `pwm_cnt`, period-end strobe, `duty`.
  - Output: registered `pwm`.
  - Contains the `act` latch.
- Top level holds:
  - the step counter, hue pointer and duty lookup;
  - the shared PWM counter.
- Parameter legality (divisibility; all parameters ≥ 1) is checked with an elaboration-time assertion.

## Test plan
All scenarios use `PWM_INTERVAL`=12, `STEPS_PER_SECTOR`=4, `STEP_INTERVAL`=3, giving `INC`=3.
- Reset → duty (12, 0, 0), `sector`=0. `pwm_r` is high every cycle from the 2nd cycle on; `pwm_g`/`pwm_b` are always low.
- `en`=1, `dir`=0 from reset:
  - 1 cycle after the first tick, `duty_g`=3.
  - After 4 ticks, `sector`=1 with duty (12, 12, 0).
  - After 24 ticks, `sector`=0 with duty (12, 0, 0), and exactly one `sector_wrap` pulse is seen.
- `dir`=1 from reset → first tick gives `sector`=5, `pos`=3, a `sector_wrap` pulse, and duty (12, 0, 3).
- `en`=0 for 50 cycles after `step_cnt` reaches 1 → duty and `sector` are frozen. After `en` returns, the tick fires exactly 2 enabled cycles later.
- Duty changes mid-PWM-period → each 12-cycle window of `pwm_g` contains exactly the duty latched at the window start. No runt pulses appear.
- `rst` asserted while in `sector`=3 → next edge shows all reset values, and `sector_wrap`=0.
